// File: rtl/stream_demux6.sv
// stream_demux6: steers one valid/ready input word per cycle into one of six
// single-entry output channels. Selects 6 and 7 are consumed, discarded and
// counted in a saturating drop counter.
module stream_demux6 #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [W-1:0]     in_data,
  output logic [5:0]       out_valid,
  input  logic [5:0]       out_ready,
  output logic [W-1:0]     out_data0,
  output logic [W-1:0]     out_data1,
  output logic [W-1:0]     out_data2,
  output logic [W-1:0]     out_data3,
  output logic [W-1:0]     out_data4,
  output logic [W-1:0]     out_data5,
  output logic [CNT_W-1:0] drop_count,
  output logic             drop_pulse
);

  localparam int unsigned NCH = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Holding registers: one valid flag and one data word per channel
  logic [NCH-1:0] vld;
  logic [W-1:0]   dat [NCH];

  logic [7:0]     ready_vec;
  logic           sel_bad;
  logic           accept;
  logic [NCH-1:0] load;
  logic [NCH-1:0] vld_nxt;
  logic           drop_evt;

  // Per-select readiness; invalid selects always accept so they can be discarded
  assign ready_vec = {2'b11, (~vld) | out_ready};
  assign sel_bad   = (in_sel >= 3'd6);

  // Combinational ready and accept decode, intentionally dependent on out_ready
  always_comb begin
    in_ready = ready_vec[in_sel];
    accept   = in_valid & in_ready;
    drop_evt = accept & sel_bad;
    load     = '0;
    for (int k = 0; k < NCH; k++) begin
      load[k] = accept & (in_sel == 3'(k));
    end
  end

  // Next valid: a load keeps/sets the flag (drain+load has no bubble), a lone drain clears it
  always_comb begin
    vld_nxt = '0;
    for (int k = 0; k < NCH; k++) begin
      vld_nxt[k] = load[k] | (vld[k] & ~out_ready[k]);
    end
  end

  // Channel registers; data is only rewritten on a load so it holds while empty
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int k = 0; k < NCH; k++) begin
        dat[k] <= '0;
      end
    end else begin
      vld <= vld_nxt;
      for (int k = 0; k < NCH; k++) begin
        if (load[k]) begin
          dat[k] <= in_data;
        end
      end
    end
  end

  // Saturating drop counter and one-cycle strobe per discarded word
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop_evt;
      if (drop_evt && (drop_count != CNT_MAX)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

  assign out_valid = vld;
  assign out_data0 = dat[0];
  assign out_data1 = dat[1];
  assign out_data2 = dat[2];
  assign out_data3 = dat[3];
  assign out_data4 = dat[4];
  assign out_data5 = dat[5];

endmodule

// File: tb/tb_stream_demux6.sv
// Directed bench for stream_demux6 with a queue-based reference model checked every cycle.
module tb_stream_demux6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_sel = 3'd0;
  logic [3:0] in_data = 4'd0;
  logic [5:0] out_valid;
  logic [5:0] out_ready = 6'd0;
  logic [3:0] out_data0, out_data1, out_data2, out_data3, out_data4, out_data5;
  logic [7:0] drop_count;
  logic       drop_pulse;

  stream_demux6 #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
    .out_data3(out_data3), .out_data4(out_data4), .out_data5(out_data5),
    .drop_count(drop_count), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a queue of at most one pending word
  bit [3:0] q [6][$];
  bit [3:0] m_last [6];
  int       m_cnt = 0;
  bit       m_pulse = 1'b0;

  function automatic bit m_ready();
    if (in_sel >= 3'd6) return 1'b1;
    return (q[in_sel].size() == 0) || (out_ready[in_sel] == 1'b1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) begin
        q[k].delete();
        m_last[k] = 4'd0;
      end
      m_cnt = 0;
      m_pulse = 1'b0;
    end else begin
      bit rdy;
      bit drop;
      rdy = m_ready();
      drop = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
      end
      if (in_valid && rdy) begin
        if (in_sel < 3'd6) begin
          q[in_sel].push_back(in_data);
          m_last[in_sel] = in_data;
        end else begin
          drop = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      m_pulse = drop;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0] mv;
      logic [3:0] dd [6];
      dd[0] = out_data0; dd[1] = out_data1; dd[2] = out_data2;
      dd[3] = out_data3; dd[4] = out_data4; dd[5] = out_data5;
      for (int k = 0; k < 6; k++) mv[k] = (q[k].size() != 0);
      chk("mdl_out_valid", 32'(out_valid), 32'(mv));
      for (int k = 0; k < 6; k++) begin
        if (dd[k] !== m_last[k]) chk($sformatf("mdl_out_data%0d", k), 32'(dd[k]), 32'(m_last[k]));
      end
      chk("mdl_drop_count", 32'(drop_count), 32'(m_cnt));
      chk("mdl_drop_pulse", 32'(drop_pulse), 32'(m_pulse));
      chk("mdl_in_ready", 32'(in_ready), 32'(m_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded)
  task automatic send(input logic [2:0] sel, input logic [3:0] data);
    in_valid = 1'b1;
    in_sel = sel;
    in_data = data;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with a word presented: nothing may load
    reset = 1'b1; in_valid = 1'b1; in_sel = 3'd2; in_data = 4'h5;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data2", 32'(out_data2), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Basic routing with all consumers stalled
    send(3'd0, 4'hA);
    send(3'd3, 4'hB);
    send(3'd5, 4'hC);
    chk("route_valid", 32'(out_valid), 32'b101001);
    chk("route_d0", 32'(out_data0), 32'hA);
    chk("route_d3", 32'(out_data3), 32'hB);
    chk("route_d5", 32'(out_data5), 32'hC);

    // Backpressure on channel 1, then release with simultaneous drain and load
    send(3'd1, 4'h1);
    in_valid = 1'b1; in_sel = 3'd1; in_data = 4'h7;
    @(negedge clk);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("bp_d1_held", 32'(out_data1), 32'h1);
    chk("bp_v1_held", 32'(out_valid[1]), 32'd1);
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out_ready[1] = 1'b0;
    chk("bp_v1_stays", 32'(out_valid[1]), 32'd1);
    chk("bp_d1_new", 32'(out_data1), 32'h7);

    // Full throughput into channel 4
    out_ready[4] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 3'd4; in_data = 4'(i);
      @(negedge clk);
      chk("tp_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("tp_d4", 32'(out_data4), 32'(i));
      chk("tp_v4", 32'(out_valid[4]), 32'd1);
    end
    in_valid = 1'b0; out_ready[4] = 1'b0;

    // Invalid selects: consumed at once, counted, one pulse each
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_sel = (j == 1) ? 3'd7 : 3'd6; in_data = 4'(j + 1);
      @(negedge clk);
      chk("drop_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("drop_pulse_hi", 32'(drop_pulse), 32'd1);
      chk("drop_count_step", 32'(drop_count), 32'(j + 1));
    end
    in_valid = 1'b0;
    tick();
    chk("drop_pulse_lo", 32'(drop_pulse), 32'd0);
    chk("drop_count_3", 32'(drop_count), 32'd3);
    chk("drop_channels", 32'(out_valid), 32'b111011);
    chk("drop_d4", 32'(out_data4), 32'h7);

    // Saturation
    in_valid = 1'b1; in_sel = 3'd7;
    repeat (300) tick();
    in_valid = 1'b0;
    chk("drop_sat", 32'(drop_count), 32'd255);
    tick();
    chk("drop_sat_hold", 32'(drop_count), 32'd255);

    // Reset mid-operation with channels 0 and 2 full
    send(3'd2, 4'h9);
    chk("mid_pre_valid", 32'(out_valid[2] & out_valid[0]), 32'd1);
    reset = 1'b1; out_ready = 6'b000101;
    in_valid = 1'b1; in_sel = 3'd2; in_data = 4'hF;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 6'd0;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_d0", 32'(out_data0), 32'd0);
    chk("mid_d2", 32'(out_data2), 32'd0);
    chk("mid_count", 32'(drop_count), 32'd0);
    tick();
    chk("mid_valid_after", 32'(out_valid), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
